fetch_stage: RTL

//  Instruction-fetch stage of the MIPS datapath: owns the PC, drives the word address into the

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_pc_reg.sv | 38 +++
 rtl/fetch_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The optional FETCH_PERF_CNT_EN macro is consumed in fetch_stage.sv.
package fetch_stage_pkg;

    // Bytes per instruction-memory word.
    localparam int IMEM_WORD_BYTES = 4;

    // sll $0,$0,0 -- the canonical MIPS NOP used for pipeline bubbles.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM encodings.
    localparam logic [1:0] FS_BOOT = 2'd0;
    localparam logic [1:0] FS_RUN  = 2'd1;
    localparam logic [1:0] FS_HALT = 2'd2;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    // Value loaded into IF/ID whenever no real instruction is passed on.
    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with next-PC selection.
// Redirect has priority over everything (including a stall); otherwise
// the PC advances by one word only when the parent enables it.
module fetch_stage_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        advance_en,
    output logic [31:0] pc
);

    logic [31:0] target;
    logic [31:0] pc_next;

    // Targets are forced word aligned so PC[1:0] can never become non-zero.
    assign target = redirect_pc & ~32'h0000_0003;

    // Next-PC mux: redirect, then sequential advance (wraps modulo 2^32), else hold.
    always_comb begin
        pc_next = pc;
        if (redirect_en)
            pc_next = target;
        else if (advance_en)
            pc_next = pc + 32'd4;
    end

    // PC register, reset to the boot vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, BOOT/RUN/HALT control.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_count/stall_count.
// fsm_state exposes the control FSM for debug.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic [1:0]  fsm_state
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH * IMEM_WORD_BYTES);

    logic [1:0]  state;
    logic [31:0] pc;
    ifid_t       ifid;
    logic        run;
    logic        out_of_range;
    logic        redirect_en;
    logic        advance_en;
    logic        halt_now;
    logic        fetch_load;

    assign run          = (state == FS_RUN);
    assign out_of_range = (pc >= IMEM_LIMIT);
    // PC only moves in RUN; BOOT presents the reset PC, HALT freezes it.
    assign redirect_en  = run & redirect_valid;
    assign advance_en   = run & ~stall & ~redirect_valid & ~out_of_range;
    // A stall or a redirect on the same edge keeps the stage alive.
    assign halt_now     = run & out_of_range & ~stall & ~redirect_valid;
    assign fetch_load   = run & ~flush & ~stall & ~out_of_range;

    fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .advance_en  (advance_en),
        .pc          (pc)
    );

    // Control FSM: one BOOT cycle, then RUN until an out-of-range fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FS_BOOT;
        end else begin
            case (state)
                FS_BOOT: state <= FS_RUN;
                FS_RUN:  if (halt_now) state <= FS_HALT;
                FS_HALT: state <= FS_HALT;
                default: state <= FS_BOOT;
            endcase
        end
    end

    // Sticky halt flag; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            halted <= 1'b0;
        else if (halt_now)
            halted <= 1'b1;
    end

    // IF/ID register: flush beats stall; out-of-range fetches never load real data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ifid <= IFID_BUBBLE;
        else if (!run || flush || (!stall && out_of_range))
            ifid <= IFID_BUBBLE;
        else if (!stall)
            ifid <= '{valid: 1'b1, instr: imem_data, pc: pc, pc4: pc + 32'd4};
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: valid fetches and RUN stall cycles (both wrap).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (fetch_load)
                fetch_count <= fetch_count + 32'd1;
            if (run && stall && !flush)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

    assign imem_addr  = pc;
    assign ifid_valid = ifid.valid;
    assign ifid_instr = ifid.instr;
    assign ifid_pc    = ifid.pc;
    assign ifid_pc4   = ifid.pc4;
    assign fsm_state  = state;

endmodule
